wb_interconnect_2m1s: RTL and testbench
=======================================

// Module: wb_interconnect_2m1s
// PURPOSE
//  Two-master, one-slave Wishbone interconnect between the core's bus masters
//  and the single memory slave.
//  M0 is the data-cache/LSU port and M1 is the instruction-cache port; both
//  share one slave (main memory).
//  Round-robin arbitration; the grant is held for a whole cycle (cyc) and the
//  winner's signals are muxed to the slave.
//  Slave responses are routed back to the granted master only. No address
//  decode: every address goes to the slave unchanged.
// PARAMETERS
//  AW   32  address width (all adr ports)
//  DW   32  data width (all dat ports)
//  SW   4   byte-select width (DW/8)
//  BLW  10  burst-length width
// PORTS
//  clk_i        in   1    clock, rising edge
//  rst_i        in   1    reset, asynchronous, active-high
//  m0_wbd_dat_i in   DW   M0 write data
//  m0_wbd_adr_i in   AW   M0 address
//  m0_wbd_sel_i in   SW   M0 byte select
//  m0_wbd_we_i  in   1    M0 write enable
//  m0_wbd_cyc_i in   1    M0 bus cycle
//  m0_wbd_stb_i in   1    M0 strobe
//  m0_wbd_dat_o out  DW   M0 read data
//  m0_wbd_ack_o out  1    M0 ack
//  m0_wbd_lack_o out 1    M0 last-beat ack
//  m0_wbd_err_o out  1    M0 error
//  m1_wbd_{dat,adr,sel,we,cyc,stb}_i in   M1 copies of the M0 inputs, same widths
//  m1_wbd_bl_i  in   BLW  M1 burst length
//  m1_wbd_bry_i in   1    M1 burst ready
//  m1_wbd_{dat,ack,lack,err}_o out        M1 copies of the M0 outputs, same widths
//  s_wbd_dat_i  in   DW   slave read data
//  s_wbd_ack_i  in   1    slave ack
//  s_wbd_lack_i in   1    slave last-beat ack
//  s_wbd_{dat,adr,sel,we,cyc,stb}_o out   to slave, same widths as M0
//  s_wbd_bl_o   out  BLW  to slave: burst length
//  s_wbd_bry_o  out  1    to slave: burst ready
// BEHAVIOUR
//  - Grant state: gnt in {NONE, M0, M1}, plus a last-served bit lst. Both are
//    registered.
//  - Reset: gnt=NONE, lst=M1 (so M0 wins the first tie). All outputs are 0
//    while in reset.
//  - Next-state rules, evaluated every rising edge:
//    - gnt==Mx and mx_cyc_i=1: hold the grant.
//    - Otherwise re-arbitrate among masters with cyc_i=1 (cyc is the request).
//      - Only one requesting: grant it.
//      - Both requesting: grant the master != lst.
//      - None requesting: gnt=NONE.
//      - On a new grant, lst <= winner.
//  - Release and regrant can happen in the same edge: when the owner drops
//    cyc while the other master requests, the other is granted at that edge
//    with no idle cycle.
//  - Latency: master cyc rises at edge N (gnt=NONE) -> s_wbd_cyc_o rises after
//    edge N+1. Once granted, the request path is purely combinational.
//  - Slave outputs follow the granted master: dat, adr, sel, we, cyc, stb.
//  - bl/bry mapping to the slave:
//    - gnt=M1: s_wbd_bl_o = m1_wbd_bl_i, s_wbd_bry_o = m1_wbd_bry_i.
//    - gnt=M0 (no burst): s_wbd_bl_o = 1, s_wbd_bry_o = 1.
//  - gnt=NONE: all s_wbd_*_o = 0.
//  - Response routing, combinational:
//    - Granted master: dat_o = s_wbd_dat_i, ack_o = s_wbd_ack_i,
//      lack_o = s_wbd_lack_i.
//    - Non-granted master: dat_o, ack_o and lack_o are all 0.
//    - A non-granted master never sees an ack.
//  - err_o is constant 0 on both masters (single slave, no decode).
//  - Reset asserted mid-transfer: the grant is dropped immediately. s_cyc_o
//    and s_stb_o go 0 asynchronously, and no ack is forwarded.
// TESTING
//  1. M0 only: cyc/stb/we=1, adr=0x00001000, dat=0x00000001, sel=0xF.
//     -> Slave sees the same values one cycle later.
//     -> A 1-cycle slave ack reaches m0 ack_o only.
//  2. M1 only: read at adr=0x00000004, bl=4, slave returns 0x00000013.
//     -> m1_dat_o=0x00000013 with ack. s_bl_o=4. m0_ack_o stays 0.
//  3. M0 and M1 raise cyc in the same cycle just after reset.
//     -> M0 granted first. After M0 drops cyc, M1 is granted at that edge.
//  4. Back-to-back contention: after step 3, both request again.
//     -> The grant alternates M1/M0 according to lst (no starvation).
//  5. M1 granted, M0 raises cyc mid-transfer.
//     -> M1 holds the grant until its cyc falls. M0's adr never appears on
//        s_adr_o meanwhile.
//  6. Assert rst_i while M0 is granted with cyc=1.
//     -> s_cyc_o=0 at once. After release, gnt=NONE and M0 must regain grant.

Source files
------------

// File: rtl/wb_interconnect_2m1s.sv
// Two-master, one-slave Wishbone interconnect with round-robin arbitration.
// The grant is held for the whole cyc of the winner; responses return only to the owner.
module wb_interconnect_2m1s #(
    parameter int AW  = 32,
    parameter int DW  = 32,
    parameter int SW  = 4,
    parameter int BLW = 10
) (
    input  logic           clk_i,
    input  logic           rst_i,

    input  logic [DW-1:0]  m0_wbd_dat_i,
    input  logic [AW-1:0]  m0_wbd_adr_i,
    input  logic [SW-1:0]  m0_wbd_sel_i,
    input  logic           m0_wbd_we_i,
    input  logic           m0_wbd_cyc_i,
    input  logic           m0_wbd_stb_i,
    output logic [DW-1:0]  m0_wbd_dat_o,
    output logic           m0_wbd_ack_o,
    output logic           m0_wbd_lack_o,
    output logic           m0_wbd_err_o,

    input  logic [DW-1:0]  m1_wbd_dat_i,
    input  logic [AW-1:0]  m1_wbd_adr_i,
    input  logic [SW-1:0]  m1_wbd_sel_i,
    input  logic           m1_wbd_we_i,
    input  logic           m1_wbd_cyc_i,
    input  logic           m1_wbd_stb_i,
    input  logic [BLW-1:0] m1_wbd_bl_i,
    input  logic           m1_wbd_bry_i,
    output logic [DW-1:0]  m1_wbd_dat_o,
    output logic           m1_wbd_ack_o,
    output logic           m1_wbd_lack_o,
    output logic           m1_wbd_err_o,

    input  logic [DW-1:0]  s_wbd_dat_i,
    input  logic           s_wbd_ack_i,
    input  logic           s_wbd_lack_i,
    output logic [DW-1:0]  s_wbd_dat_o,
    output logic [AW-1:0]  s_wbd_adr_o,
    output logic [SW-1:0]  s_wbd_sel_o,
    output logic           s_wbd_we_o,
    output logic           s_wbd_cyc_o,
    output logic           s_wbd_stb_o,
    output logic [BLW-1:0] s_wbd_bl_o,
    output logic           s_wbd_bry_o
);

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_M0   = 2'd1,
        GNT_M1   = 2'd2
    } gnt_t;

    gnt_t gnt_q, gnt_d;
    // Last-served master: 0 = M0, 1 = M1.
    logic lst_q, lst_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            gnt_q <= GNT_NONE;
            lst_q <= 1'b1;
        end else begin
            gnt_q <= gnt_d;
            lst_q <= lst_d;
        end
    end

    // The owner keeps the bus while its cyc is high; otherwise re-arbitrate at
    // this edge, which lets the other master take over with no idle cycle.
    always_comb begin
        gnt_d = gnt_q;
        lst_d = lst_q;
        if ((gnt_q == GNT_M0) && m0_wbd_cyc_i) begin
            gnt_d = GNT_M0;
        end else if ((gnt_q == GNT_M1) && m1_wbd_cyc_i) begin
            gnt_d = GNT_M1;
        end else if (m0_wbd_cyc_i && m1_wbd_cyc_i) begin
            gnt_d = lst_q ? GNT_M0 : GNT_M1;
            lst_d = ~lst_q;
        end else if (m0_wbd_cyc_i) begin
            gnt_d = GNT_M0;
            lst_d = 1'b0;
        end else if (m1_wbd_cyc_i) begin
            gnt_d = GNT_M1;
            lst_d = 1'b1;
        end else begin
            gnt_d = GNT_NONE;
        end
    end

    // Request mux and response routing; everything idles to 0 without a grant.
    always_comb begin
        s_wbd_dat_o   = '0;
        s_wbd_adr_o   = '0;
        s_wbd_sel_o   = '0;
        s_wbd_we_o    = 1'b0;
        s_wbd_cyc_o   = 1'b0;
        s_wbd_stb_o   = 1'b0;
        s_wbd_bl_o    = '0;
        s_wbd_bry_o   = 1'b0;
        m0_wbd_dat_o  = '0;
        m0_wbd_ack_o  = 1'b0;
        m0_wbd_lack_o = 1'b0;
        m1_wbd_dat_o  = '0;
        m1_wbd_ack_o  = 1'b0;
        m1_wbd_lack_o = 1'b0;
        case (gnt_q)
            GNT_M0: begin
                s_wbd_dat_o   = m0_wbd_dat_i;
                s_wbd_adr_o   = m0_wbd_adr_i;
                s_wbd_sel_o   = m0_wbd_sel_i;
                s_wbd_we_o    = m0_wbd_we_i;
                s_wbd_cyc_o   = m0_wbd_cyc_i;
                s_wbd_stb_o   = m0_wbd_stb_i;
                // M0 never bursts: present it as single-beat, always ready.
                s_wbd_bl_o    = BLW'(1);
                s_wbd_bry_o   = 1'b1;
                m0_wbd_dat_o  = s_wbd_dat_i;
                m0_wbd_ack_o  = s_wbd_ack_i;
                m0_wbd_lack_o = s_wbd_lack_i;
            end
            GNT_M1: begin
                s_wbd_dat_o   = m1_wbd_dat_i;
                s_wbd_adr_o   = m1_wbd_adr_i;
                s_wbd_sel_o   = m1_wbd_sel_i;
                s_wbd_we_o    = m1_wbd_we_i;
                s_wbd_cyc_o   = m1_wbd_cyc_i;
                s_wbd_stb_o   = m1_wbd_stb_i;
                s_wbd_bl_o    = m1_wbd_bl_i;
                s_wbd_bry_o   = m1_wbd_bry_i;
                m1_wbd_dat_o  = s_wbd_dat_i;
                m1_wbd_ack_o  = s_wbd_ack_i;
                m1_wbd_lack_o = s_wbd_lack_i;
            end
            default: begin
            end
        endcase
    end

    // Single slave with no decode, so nothing can ever error.
    assign m0_wbd_err_o = 1'b0;
    assign m1_wbd_err_o = 1'b0;

endmodule

// File: tb/tb_wb_interconnect_2m1s.sv
// Directed bench for wb_interconnect_2m1s with a scoreboard of expected slave transactions.
module tb_wb_interconnect_2m1s;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] m0_wbd_dat_i, m0_wbd_adr_i, m1_wbd_dat_i, m1_wbd_adr_i;
    logic [3:0]  m0_wbd_sel_i, m1_wbd_sel_i;
    logic        m0_wbd_we_i, m0_wbd_cyc_i, m0_wbd_stb_i;
    logic        m1_wbd_we_i, m1_wbd_cyc_i, m1_wbd_stb_i;
    logic [9:0]  m1_wbd_bl_i;
    logic        m1_wbd_bry_i;
    logic [31:0] m0_wbd_dat_o, m1_wbd_dat_o;
    logic        m0_wbd_ack_o, m0_wbd_lack_o, m0_wbd_err_o;
    logic        m1_wbd_ack_o, m1_wbd_lack_o, m1_wbd_err_o;
    logic [31:0] s_wbd_dat_i;
    logic        s_wbd_ack_i, s_wbd_lack_i;
    logic [31:0] s_wbd_dat_o, s_wbd_adr_o;
    logic [3:0]  s_wbd_sel_o;
    logic        s_wbd_we_o, s_wbd_cyc_o, s_wbd_stb_o;
    logic [9:0]  s_wbd_bl_o;
    logic        s_wbd_bry_o;

    wb_interconnect_2m1s dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .m0_wbd_dat_i(m0_wbd_dat_i), .m0_wbd_adr_i(m0_wbd_adr_i), .m0_wbd_sel_i(m0_wbd_sel_i),
        .m0_wbd_we_i(m0_wbd_we_i), .m0_wbd_cyc_i(m0_wbd_cyc_i), .m0_wbd_stb_i(m0_wbd_stb_i),
        .m0_wbd_dat_o(m0_wbd_dat_o), .m0_wbd_ack_o(m0_wbd_ack_o), .m0_wbd_lack_o(m0_wbd_lack_o),
        .m0_wbd_err_o(m0_wbd_err_o),
        .m1_wbd_dat_i(m1_wbd_dat_i), .m1_wbd_adr_i(m1_wbd_adr_i), .m1_wbd_sel_i(m1_wbd_sel_i),
        .m1_wbd_we_i(m1_wbd_we_i), .m1_wbd_cyc_i(m1_wbd_cyc_i), .m1_wbd_stb_i(m1_wbd_stb_i),
        .m1_wbd_bl_i(m1_wbd_bl_i), .m1_wbd_bry_i(m1_wbd_bry_i),
        .m1_wbd_dat_o(m1_wbd_dat_o), .m1_wbd_ack_o(m1_wbd_ack_o), .m1_wbd_lack_o(m1_wbd_lack_o),
        .m1_wbd_err_o(m1_wbd_err_o),
        .s_wbd_dat_i(s_wbd_dat_i), .s_wbd_ack_i(s_wbd_ack_i), .s_wbd_lack_i(s_wbd_lack_i),
        .s_wbd_dat_o(s_wbd_dat_o), .s_wbd_adr_o(s_wbd_adr_o), .s_wbd_sel_o(s_wbd_sel_o),
        .s_wbd_we_o(s_wbd_we_o), .s_wbd_cyc_o(s_wbd_cyc_o), .s_wbd_stb_o(s_wbd_stb_o),
        .s_wbd_bl_o(s_wbd_bl_o), .s_wbd_bry_o(s_wbd_bry_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int          m;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic        we;
        logic [9:0]  bl;
        logic        bry;
    } txn_t;

    txn_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   lst_m  = 1;
    int   k;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Record what the slave should see once master m owns the bus.
    task automatic push_m(input int m);
        txn_t e;
        e.m = m;
        if (m == 0) begin
            e.adr = m0_wbd_adr_i; e.dat = m0_wbd_dat_i; e.sel = m0_wbd_sel_i;
            e.we  = m0_wbd_we_i;  e.bl  = 10'd1;        e.bry = 1'b1;
        end else begin
            e.adr = m1_wbd_adr_i; e.dat = m1_wbd_dat_i; e.sel = m1_wbd_sel_i;
            e.we  = m1_wbd_we_i;  e.bl  = m1_wbd_bl_i;  e.bry = m1_wbd_bry_i;
        end
        sb.push_back(e);
    endtask

    // Simultaneous request: the master that was not served last goes first.
    task automatic push_pair();
        if (lst_m == 1) begin push_m(0); push_m(1); end
        else begin push_m(1); push_m(0); end
    endtask

    task automatic req(input int m, input logic [31:0] adr, input logic [31:0] dat, input logic we);
        if (m == 0) begin
            m0_wbd_adr_i = adr; m0_wbd_dat_i = dat; m0_wbd_we_i = we;
            m0_wbd_sel_i = 4'hF; m0_wbd_cyc_i = 1'b1; m0_wbd_stb_i = 1'b1;
        end else begin
            m1_wbd_adr_i = adr; m1_wbd_dat_i = dat; m1_wbd_we_i = we;
            m1_wbd_sel_i = 4'h3; m1_wbd_cyc_i = 1'b1; m1_wbd_stb_i = 1'b1;
        end
    endtask

    task automatic drop(input int m);
        if (m == 0) begin m0_wbd_cyc_i = 1'b0; m0_wbd_stb_i = 1'b0; end
        else begin m1_wbd_cyc_i = 1'b0; m1_wbd_stb_i = 1'b0; end
    endtask

    // Wait (bounded) for a slave request, compare it to the scoreboard head,
    // ack it for one cycle and check that only the owner sees the response.
    task automatic serve(input logic [31:0] rdata, output int waited);
        txn_t e;
        waited = 0;
        #1;
        while (!(s_wbd_cyc_o && s_wbd_stb_o) && waited < 20) begin
            @(posedge clk_i); #1;
            waited++;
        end
        chk("grant_timeout", 32'(waited < 20), 32'd1);
        if (sb.size() == 0) begin
            n_chk++; n_fail++;
            $error("FAIL sb_underflow observed=empty expected=pending txn");
            return;
        end
        e = sb.pop_front();
        chk("s_adr", s_wbd_adr_o, e.adr);
        chk("s_dat", s_wbd_dat_o, e.dat);
        chk("s_sel", 32'(s_wbd_sel_o), 32'(e.sel));
        chk("s_we",  32'(s_wbd_we_o),  32'(e.we));
        chk("s_bl",  32'(s_wbd_bl_o),  32'(e.bl));
        chk("s_bry", 32'(s_wbd_bry_o), 32'(e.bry));
        s_wbd_dat_i = rdata; s_wbd_ack_i = 1'b1; s_wbd_lack_i = 1'b1;
        #1;
        if (e.m == 0) begin
            chk("m0_ack",  32'(m0_wbd_ack_o),  32'd1);
            chk("m0_lack", 32'(m0_wbd_lack_o), 32'd1);
            chk("m0_dat",  m0_wbd_dat_o, rdata);
            chk("m1_ack_off", 32'(m1_wbd_ack_o), 32'd0);
            chk("m1_dat_off", m1_wbd_dat_o, 32'd0);
        end else begin
            chk("m1_ack",  32'(m1_wbd_ack_o),  32'd1);
            chk("m1_lack", 32'(m1_wbd_lack_o), 32'd1);
            chk("m1_dat",  m1_wbd_dat_o, rdata);
            chk("m0_ack_off", 32'(m0_wbd_ack_o), 32'd0);
            chk("m0_dat_off", m0_wbd_dat_o, 32'd0);
        end
        $display("txn: master=M%0d adr=0x%08h we=%0b bl=%0d rdata=0x%08h waited=%0d",
                 e.m, e.adr, e.we, e.bl, rdata, waited);
        lst_m = e.m;
        @(posedge clk_i); #1;
        s_wbd_ack_i = 1'b0; s_wbd_lack_i = 1'b0; s_wbd_dat_i = 32'd0;
    endtask

    initial begin
        rst_i = 1'b1;
        m0_wbd_dat_i = '0; m0_wbd_adr_i = '0; m0_wbd_sel_i = '0;
        m0_wbd_we_i = 1'b0; m0_wbd_cyc_i = 1'b0; m0_wbd_stb_i = 1'b0;
        m1_wbd_dat_i = '0; m1_wbd_adr_i = '0; m1_wbd_sel_i = '0;
        m1_wbd_we_i = 1'b0; m1_wbd_cyc_i = 1'b0; m1_wbd_stb_i = 1'b0;
        m1_wbd_bl_i = '0; m1_wbd_bry_i = 1'b0;
        s_wbd_dat_i = 32'hFFFF_FFFF; s_wbd_ack_i = 1'b1; s_wbd_lack_i = 1'b1;

        // Reset: a live request and a stray slave ack must not leak through.
        req(0, 32'h0000_0ABC, 32'h1234_5678, 1'b1);
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_s_cyc", 32'(s_wbd_cyc_o), 32'd0);
        chk("rst_s_stb", 32'(s_wbd_stb_o), 32'd0);
        chk("rst_s_adr", s_wbd_adr_o, 32'd0);
        chk("rst_m0_ack", 32'(m0_wbd_ack_o), 32'd0);
        chk("rst_m0_dat", m0_wbd_dat_o, 32'd0);
        chk("rst_m1_ack", 32'(m1_wbd_ack_o), 32'd0);
        chk("err_tie", 32'({m0_wbd_err_o, m1_wbd_err_o}), 32'd0);
        drop(0);
        s_wbd_ack_i = 1'b0; s_wbd_lack_i = 1'b0; s_wbd_dat_i = 32'd0;
        rst_i = 1'b0;

        // 1. M0 alone, one-cycle grant latency.
        @(posedge clk_i); #1;
        req(0, 32'h0000_1000, 32'h0000_0001, 1'b1);
        push_m(0);
        #1;
        chk("s1_idle_cyc", 32'(s_wbd_cyc_o), 32'd0);
        serve(32'h0000_0000, k);
        chk("s1_latency", 32'(k), 32'd1);
        drop(0);
        @(posedge clk_i); #1;
        chk("s1_release", 32'(s_wbd_cyc_o), 32'd0);

        // 2. M1 burst read.
        req(1, 32'h0000_0004, 32'h0000_0000, 1'b0);
        m1_wbd_bl_i = 10'd4; m1_wbd_bry_i = 1'b0;
        push_m(1);
        serve(32'h0000_0013, k);
        drop(1);
        @(posedge clk_i); #1;

        // 3. Tie straight after reset: M0 first, M1 granted on M0's release edge.
        rst_i = 1'b1; lst_m = 1;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        req(0, 32'h0000_2000, 32'hCAFE_0000, 1'b1);
        req(1, 32'h0000_0040, 32'h0000_0000, 1'b0);
        m1_wbd_bl_i = 10'd2; m1_wbd_bry_i = 1'b1;
        push_pair();
        serve(32'h0000_000A, k);
        chk("s3_first_lat", 32'(k), 32'd1);
        drop(lst_m);
        serve(32'h0000_000B, k);
        chk("s3_regrant_lat", 32'(k), 32'd1);
        drop(lst_m);
        @(posedge clk_i); #1;

        // 4. Repeated contention alternates according to the last-served master.
        req(0, 32'h0000_0101, 32'h0000_0011, 1'b1);
        req(1, 32'h0000_0201, 32'h0000_0000, 1'b0);
        push_pair();
        serve(32'h0000_0021, k); drop(lst_m);
        serve(32'h0000_0022, k); drop(lst_m);
        @(posedge clk_i); #1;
        req(0, 32'h0000_0102, 32'h0000_0012, 1'b1);
        push_m(0);
        serve(32'h0000_0023, k); drop(lst_m);
        @(posedge clk_i); #1;
        req(0, 32'h0000_0103, 32'h0000_0013, 1'b1);
        req(1, 32'h0000_0203, 32'h0000_0000, 1'b0);
        push_pair();
        serve(32'h0000_0024, k); drop(lst_m);
        serve(32'h0000_0025, k); drop(lst_m);
        @(posedge clk_i); #1;

        // 5. M0 requests while M1 owns the bus.
        req(1, 32'h0000_0300, 32'h0000_0000, 1'b0);
        m1_wbd_bl_i = 10'd8;
        push_m(1);
        @(posedge clk_i); #1;
        req(0, 32'hDEAD_0000, 32'h0000_0055, 1'b1);
        push_m(0);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("s5_hold_adr", s_wbd_adr_o, 32'h0000_0300);
            @(posedge clk_i); #1;
        end
        serve(32'h0000_0031, k); drop(lst_m);
        serve(32'h0000_0032, k);
        chk("s5_regrant_lat", 32'(k), 32'd1);
        drop(lst_m);
        @(posedge clk_i); #1;

        // 6. Reset in the middle of an M0 transfer.
        req(0, 32'h0000_0600, 32'h0000_0066, 1'b1);
        @(posedge clk_i); #1;
        chk("s6_granted", 32'(s_wbd_cyc_o), 32'd1);
        s_wbd_ack_i = 1'b1; s_wbd_dat_i = 32'h0000_0077;
        rst_i = 1'b1;
        #1;
        chk("s6_rst_cyc", 32'(s_wbd_cyc_o), 32'd0);
        chk("s6_rst_stb", 32'(s_wbd_stb_o), 32'd0);
        chk("s6_rst_ack", 32'(m0_wbd_ack_o), 32'd0);
        @(posedge clk_i); #1;
        rst_i = 1'b0; s_wbd_ack_i = 1'b0; s_wbd_dat_i = 32'd0; lst_m = 1;
        #1;
        chk("s6_none", 32'(s_wbd_cyc_o), 32'd0);
        push_m(0);
        serve(32'h0000_0088, k);
        chk("s6_regain_lat", 32'(k), 32'd1);
        drop(0);
        @(posedge clk_i); #1;

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
